// File: rtl/sa_stream_pkg.sv
// Shared definitions for the systolic-array stream width converters
// (stream_packer now, stream_unpacker later): default sizes, clog2 and
// lane-slice helper macros.
`ifndef SA_STREAM_PKG_SV
`define SA_STREAM_PKG_SV

// Part-select for lane k of a vector built from w-bit lanes.
`define SA_LANE(k, w) ((k) * (w)) +: (w)

package sa_stream_pkg;

  localparam int SA_DEF_DATA_WIDTH = 32;
  localparam int SA_DEF_RATIO      = 4;

  // Packer fill state: EMPTY means lane index 0 and nothing assembled yet.
  typedef enum logic {
    PK_EMPTY   = 1'b0,
    PK_FILLING = 1'b1
  } pk_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int sa_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/stream_packer.sv
// stream_packer: gathers RATIO narrow valid/ready words into one wide beat.
// s_last closes a beat early; m_keep marks which lanes hold real words.
// Build option: define PACKER_ZERO_PAD_EN to force unkept lanes of m_data
// to zero; otherwise unkept lanes carry stale assembly contents.
module stream_packer
  import sa_stream_pkg::*;
#(
  parameter int DATA_WIDTH = SA_DEF_DATA_WIDTH,
  parameter int RATIO      = SA_DEF_RATIO
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]            m_keep,
  output logic                        m_last
);

  localparam int IDX_W  = (sa_clog2(RATIO) < 1) ? 1 : sa_clog2(RATIO);
  localparam int BEAT_W = DATA_WIDTH * RATIO;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  pk_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BEAT_W-1:0]  asm_data_q, asm_data_d;
  logic [RATIO-1:0]   asm_keep_q, asm_keep_d;
  logic [BEAT_W-1:0]  m_data_q, m_data_d;
  logic [RATIO-1:0]   m_keep_q, m_keep_d;
  logic               m_last_q, m_last_d;
  logic               m_valid_q, m_valid_d;

  logic               pready;
  logic               accept;
  logic               complete;
  logic               beat_open;
  logic [BEAT_W-1:0]  lane_data;
  logic [RATIO-1:0]   lane_keep;
  logic [BEAT_W-1:0]  beat_data;

  // Handshake: the output register can take a new beat if empty or draining.
  assign pready   = m_ready | ~m_valid_q;
  assign s_ready  = ~rst & pready;
  assign accept   = s_valid & s_ready;
  assign complete = accept & ((idx_q == IDX_LAST) | s_last);

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

  // Merge the incoming word into lane idx of the assembly contents.
  always_comb begin
    lane_data = asm_data_q;
    lane_keep = beat_open ? asm_keep_q : '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx_q == IDX_W'(k)) begin
        lane_data[`SA_LANE(k, DATA_WIDTH)] = s_data;
        lane_keep[k] = 1'b1;
      end
    end
  end

`ifdef PACKER_ZERO_PAD_EN
  // Unkept lanes present neutral (zero) operands to the array.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_pad
      assign beat_data[`SA_LANE(gi, DATA_WIDTH)] =
        lane_keep[gi] ? lane_data[`SA_LANE(gi, DATA_WIDTH)] : '0;
    end
  endgenerate
`else
  assign beat_data = lane_data;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PK_EMPTY;
    else     state_q <= state_d;
  end

  // FSM next state: open a beat on a non-completing accept, close on completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PK_EMPTY:   if (accept && !complete) state_d = PK_FILLING;
      PK_FILLING: if (complete)            state_d = PK_EMPTY;
      default:    state_d = PK_EMPTY;
    endcase
  end

  // FSM outputs: previously assembled lanes only count while a beat is open.
  always_comb begin
    beat_open = (state_q == PK_FILLING);
  end

  // Datapath next values: lane counter, assembly and output register.
  always_comb begin
    idx_d      = idx_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (accept) begin
      asm_data_d = lane_data;
      if (complete) begin
        idx_d      = '0;
        asm_keep_d = '0;
        m_data_d   = beat_data;
        m_keep_d   = lane_keep;
        m_last_d   = s_last;
        m_valid_d  = 1'b1;
      end else begin
        idx_d      = idx_q + IDX_W'(1);
        asm_keep_d = lane_keep;
      end
    end
  end

  // Datapath registers; reset discards partial assembly and any held beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (DATA_WIDTH=8, RATIO=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stream_packer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] held;

  stream_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_keep(m_keep), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word for one clock, ending on the next falling edge.
  task automatic drive(input logic [7:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_m_keep", {28'd0, m_keep}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_s_ready", {31'd0, s_ready}, 32'd1);
    $display("step reset: done");

    // Full beat closed by s_last on the fourth word.
    drive(8'h11, 1'b0); drive(8'h22, 1'b0); drive(8'h33, 1'b0); drive(8'h44, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    check("t1_m_valid", {31'd0, m_valid}, 32'd1);
    check("t1_m_data", m_data, 32'h44332211);
    check("t1_m_keep", {28'd0, m_keep}, 32'hF);
    check("t1_m_last", {31'd0, m_last}, 32'd1);
    idle();
    check("t1_drained", {31'd0, m_valid}, 32'd0);
    $display("step full beat: m_data=%h", 32'h44332211);

    // Two-lane partial beat.
    drive(8'hA1, 1'b0); drive(8'hA2, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    check("t2_m_valid", {31'd0, m_valid}, 32'd1);
    check("t2_m_keep", {28'd0, m_keep}, 32'h3);
    check("t2_lo16", {16'd0, m_data[15:0]}, 32'h0000A2A1);
    check("t2_m_last", {31'd0, m_last}, 32'd1);
`ifdef PACKER_ZERO_PAD_EN
    check("t2_pad", {16'd0, m_data[31:16]}, 32'd0);
`endif
    idle();
    $display("step partial beat: keep=0011");

    // Eight back-to-back words: s_ready must stay high throughout.
    for (int i = 1; i <= 8; i++) begin
      check("t3_s_ready", {31'd0, s_ready}, 32'd1);
      if (i == 5) begin
        check("t3_b1_valid", {31'd0, m_valid}, 32'd1);
        check("t3_b1_data", m_data, 32'h04030201);
        check("t3_b1_last", {31'd0, m_last}, 32'd0);
      end
      drive(8'(i), 1'b0);
    end
    s_valid = 1'b0;
    check("t3_b2_valid", {31'd0, m_valid}, 32'd1);
    check("t3_b2_data", m_data, 32'h08070605);
    check("t3_b2_keep", {28'd0, m_keep}, 32'hF);
    idle();
    $display("step stream: two beats");

    // Back-pressure: beat held while a further word waits upstream.
    m_ready = 1'b0;
    drive(8'hB1, 1'b0); drive(8'hB2, 1'b0); drive(8'hB3, 1'b0); drive(8'hB4, 1'b0);
    s_valid = 1'b1; s_data = 8'hC1; s_last = 1'b1;
    check("t4_valid", {31'd0, m_valid}, 32'd1);
    check("t4_data", m_data, 32'hB4B3B2B1);
    check("t4_s_ready", {31'd0, s_ready}, 32'd0);
    held = m_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t4_hold_data", m_data, held);
      check("t4_hold_valid", {31'd0, m_valid}, 32'd1);
      check("t4_hold_s_ready", {31'd0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("t4_reload_valid", {31'd0, m_valid}, 32'd1);
    check("t4_reload_keep", {28'd0, m_keep}, 32'h1);
    check("t4_reload_lane0", {24'd0, m_data[7:0]}, 32'h000000C1);
    check("t4_reload_last", {31'd0, m_last}, 32'd1);
    idle();
    $display("step backpressure: held 3 cycles, reload no bubble");

    // Single word with s_last at lane 0.
    drive(8'hD5, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    check("t5_keep", {28'd0, m_keep}, 32'h1);
    check("t5_last", {31'd0, m_last}, 32'd1);
    check("t5_lane0", {24'd0, m_data[7:0]}, 32'h000000D5);
`ifdef PACKER_ZERO_PAD_EN
    check("t5_pad", {8'd0, m_data[31:8]}, 32'd0);
`endif
    idle();
    $display("step single word: keep=0001");

    // Reset in the middle of a beat discards the partial lanes.
    drive(8'hE1, 1'b0); drive(8'hE2, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("t6_rst_m_valid", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    check("t6_rst_m_valid2", {31'd0, m_valid}, 32'd0);
    rst = 1'b0;
    drive(8'h55, 1'b0); drive(8'h66, 1'b0); drive(8'h77, 1'b0); drive(8'h88, 1'b1);
    s_valid = 1'b0; s_last = 1'b0;
    check("t6_data", m_data, 32'h88776655);
    check("t6_keep", {28'd0, m_keep}, 32'hF);
    check("t6_valid", {31'd0, m_valid}, 32'd1);
    idle();
    $display("step mid-beat reset: m_data=%h", 32'h88776655);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_packer.md
Name: stream_packer

Overview:
Width-converting stream stage that sits directly downstream of the skid_buffer on the operand path. It gathers RATIO consecutive narrow words from a valid/ready stream into one wide beat for a systolic-array row feeder. An s_last flag closes a partial beat early and marks the end of a vector. Full throughput (one narrow word per cycle) whenever the downstream side is ready.

Parameters:
DATA_WIDTH, 32, width of one narrow input word
RATIO, 4, narrow words per wide output beat (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
s_valid  input  1  narrow word valid
s_ready  output  1  packer can accept a word
s_data  input  DATA_WIDTH  narrow word
s_last  input  1  final word of the vector; closes the current beat
m_valid  output  1  wide beat valid
m_ready  input  1  downstream accepts the beat
m_data  output  DATA_WIDTH*RATIO  wide beat; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
m_keep  output  RATIO  bit k set = lane k holds a valid word
m_last  output  1  beat ends a vector

Behaviour:
- Reset (async assert, sync-released use): m_valid=0, m_data=0, m_keep=0, m_last=0, lane index idx=0, assembly register=0. s_ready=0 while rst is high.
- Reset mid-beat discards any partial assembly and any held output beat.
- Pipeline ready: pready = m_ready | ~m_valid. s_ready = ~rst & pready. s_ready is combinational from m_ready and m_valid only, never from s_data or s_last.
- Accept: s_valid & s_ready. On accept, s_data is written into assembly lane idx and keep bit idx is set.
- Beat completes on accept when idx==RATIO-1 or s_last==1.
  - Completing accept: load m_data with the assembly contents plus the incoming word; set m_keep, m_last=s_last, m_valid=1; reset idx to 0 and clear assembly keep.
  - Non-completing accept: idx <= idx+1.
- Output hold: m_valid & ~m_ready keeps m_data, m_keep and m_last stable. s_ready is low, so idx and assembly do not change.
- Output drain: m_valid & m_ready with no completing accept in the same cycle sets m_valid to 0. A simultaneous drain and completing accept reloads the beat back-to-back with no bubble.
- Latency: one cycle from the completing accept to m_valid.
- States: EMPTY (idx=0, no partial beat) and FILLING (0<idx<RATIO). Output register full or empty is tracked separately by m_valid.
- s_last at idx=0 gives a 1-lane beat with m_keep=...0001.
- An s_valid pulse with s_ready low is ignored. The upstream stage must hold the word.
- idx width is clog2(RATIO). It never exceeds RATIO-1 and wraps to 0 only through beat completion.

Optional Feature:
PACKER_ZERO_PAD_EN.
- Defined: lanes with m_keep=0 are driven to zero in m_data, so the array sees neutral operands.
- Undefined: unkept lanes are don't-care (whatever the assembly register holds), which saves muxes. The bench checks only kept lanes.

Decomposition:
- Shared package sa_stream_pkg holds:
  - the clog2 function
  - the default DATA_WIDTH and RATIO constants
  - lane-slice helper macros used by all width converters
- No sub-module; the lane counter and assembly register are inline.
- A matching stream_unpacker will reuse sa_stream_pkg.

Test Plan:
- DATA_WIDTH=8, RATIO=4, m_ready=1; send 0x11,0x22,0x33,0x44 with last on 0x44 -> one cycle after the last accept: m_data=0x44332211, m_keep=4'b1111, m_last=1.
- Send 0xA1,0xA2 with last on 0xA2 -> m_keep=4'b0011, m_data[15:0]=0xA2A1. With PACKER_ZERO_PAD_EN, m_data[31:16]=0.
- Continuous stream of 8 words, m_ready=1 -> two beats on consecutive-beat cycles, s_ready never drops, no bubble.
- Beat held with m_ready=0 for 3 cycles -> s_ready=0, m_data stable. When m_ready rises, the next beat loads in the same cycle it drains.
- Single word with s_last at idx=0 -> m_keep=4'b0001, m_last=1.
- Assert rst after 2 of 4 words, then send 0x55,0x66,0x77,0x88 -> beat is 0x88776655; no stale lanes, m_valid=0 during reset.
